// File: rtl/muldiv_seq.sv
// muldiv_seq: multi-cycle unsigned multiply sequencer (MULTU).
//
// Computes op_a * op_b with a shift-add loop. Each iteration borrows the
// shared ALU for one granted cycle and uses only its add operation. The
// 64-bit product is left in HI/LO, where mfhi/mflo read it.
//
// Ports:
//   clk, reset         rising-edge clock, asynchronous active-high reset
//   start, op_a, op_b  start request and operands (accepted only in IDLE)
//   busy, done         busy in MUL/DONE; done pulses once the product is final
//   hi, lo             upper/lower product words
//   alu_req, alu_gnt   shared-ALU request and same-cycle grant
//   alu_srca/srcb      ALU operands driven while in MUL
//   alu_control        ALU opcode (add while in MUL)
//   alu_out            combinational ALU result for the current operands
module muldiv_seq #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CNT_W = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             alu_req,
    input  logic             alu_gnt,
    output logic [WIDTH-1:0] alu_srca,
    output logic [WIDTH-1:0] alu_srcb,
    output logic [2:0]       alu_control,
    input  logic [WIDTH-1:0] alu_out
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_MUL,
        S_DONE
    } state_t;

    localparam logic [2:0]       ALU_ADD = 3'b010;
    localparam logic [CNT_W-1:0] LAST    = CNT_W'(WIDTH - 1);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic [WIDTH-1:0] mcand_q, mcand_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             carry;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            hi_q    <= '0;
            lo_q    <= '0;
            mcand_q <= '0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            mcand_q <= mcand_d;
            count_q <= count_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        hi_d        = hi_q;
        lo_d        = lo_q;
        mcand_d     = mcand_q;
        count_d     = count_q;
        alu_req     = 1'b0;
        alu_srca    = '0;
        alu_srcb    = '0;
        alu_control = 3'b000;
        carry       = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    mcand_d = op_a;
                    lo_d    = op_b;
                    hi_d    = '0;
                    count_d = '0;
                    state_d = S_MUL;
                end
            end
            S_MUL: begin
                alu_req     = 1'b1;
                alu_srca    = hi_q;
                alu_srcb    = lo_q[0] ? mcand_q : '0;
                alu_control = ALU_ADD;
                // The shared ALU has no carry out; recover it from the operand
                // and sum MSBs (a carry occurred iff both MSBs set, or one set
                // and the sum MSB cleared).
                carry = (alu_srca[WIDTH-1] & alu_srcb[WIDTH-1]) |
                        ((alu_srca[WIDTH-1] | alu_srcb[WIDTH-1]) & ~alu_out[WIDTH-1]);
                if (alu_gnt) begin
                    // {carry, sum, lo} shifted right by one bit.
                    hi_d    = {carry, alu_out[WIDTH-1:1]};
                    lo_d    = {alu_out[0], lo_q[WIDTH-1:1]};
                    count_d = count_q + CNT_W'(1);
                    if (count_q == LAST) begin
                        state_d = S_DONE;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign busy = (state_q == S_MUL) || (state_q == S_DONE);
    assign done = (state_q == S_DONE);
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: tb/tb_muldiv_seq.sv
module tb_muldiv_seq;

    localparam int unsigned WIDTH = 32;

    logic             clk = 1'b0;
    logic             reset;
    logic             start;
    logic [WIDTH-1:0] op_a, op_b;
    logic             busy, done;
    logic [WIDTH-1:0] hi, lo;
    logic             alu_req;
    logic             alu_gnt;
    logic [WIDTH-1:0] alu_srca, alu_srcb;
    logic [2:0]       alu_control;
    logic [WIDTH-1:0] alu_out;

    muldiv_seq #(
        .WIDTH(WIDTH),
        .CNT_W(6)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .op_a       (op_a),
        .op_b       (op_b),
        .busy       (busy),
        .done       (done),
        .hi         (hi),
        .lo         (lo),
        .alu_req    (alu_req),
        .alu_gnt    (alu_gnt),
        .alu_srca   (alu_srca),
        .alu_srcb   (alu_srcb),
        .alu_control(alu_control),
        .alu_out    (alu_out)
    );

    always #5 clk = ~clk;

    // Shared ALU: only add is meaningful here; any other opcode yields junk.
    assign alu_out = (alu_control == 3'b010) ? (alu_srca + alu_srcb) : 32'hDEAD_BEEF;

    int unsigned n_cmp = 0;
    int unsigned n_err = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    typedef struct {
        logic [63:0] prod;
        int unsigned lat;
    } exp_t;

    exp_t sb[$];

    // Cycle model: independent 33-bit add formulation of the shift-add loop.
    int unsigned      m_st  = 0;   // 0 idle, 1 mul, 2 done
    logic [WIDTH-1:0] m_hi  = '0;
    logic [WIDTH-1:0] m_lo  = '0;
    logic [WIDTH-1:0] m_mc  = '0;
    int unsigned      m_cnt = 0;
    int unsigned      bcnt  = 0;

    always @(posedge clk) begin
        logic [WIDTH:0] sum;
        exp_t e;
        if (reset) begin
            m_st = 0; m_hi = '0; m_lo = '0; m_mc = '0; m_cnt = 0;
        end else begin
            case (m_st)
                0: if (start) begin
                    m_mc = op_a; m_lo = op_b; m_hi = '0; m_cnt = 0; m_st = 1;
                end
                1: if (alu_gnt) begin
                    sum = {1'b0, m_hi} + {1'b0, (m_lo[0] ? m_mc : '0)};
                    {m_hi, m_lo} = {sum, m_lo[WIDTH-1:1]};
                    m_cnt++;
                    if (m_cnt == WIDTH) m_st = 2;
                end
                default: m_st = 0;
            endcase
        end
        #2;
        if (reset) begin
            bcnt = 0;
        end else begin
            check("ctl", {58'd0, busy, done, alu_req, alu_control},
                  {58'd0, m_st != 0, m_st == 2, m_st == 1, (m_st == 1) ? 3'b010 : 3'b000});
            check("src", {alu_srca, alu_srcb},
                  (m_st == 1) ? {m_hi, (m_lo[0] ? m_mc : 32'd0)} : 64'd0);
            check("hilo", {hi, lo}, {m_hi, m_lo});
            if (busy) bcnt++;
            if (done) begin
                if (sb.size() == 0) begin
                    check("unexpected_done", 64'd1, 64'd0);
                end else begin
                    e = sb.pop_front();
                    check("product", {hi, lo}, e.prod);
                    check("latency", 64'(bcnt), 64'(e.lat));
                end
            end
            if (!busy) bcnt = 0;
        end
    end

    task automatic run_mul(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                           input int unsigned nstall, input bit poke);
        logic [41:0] pat;
        int unsigned placed;
        int unsigned p;
        int unsigned k;
        pat = '1;
        placed = 0;
        // Stalls never land on the final MUL cycle, so exactly WIDTH grants
        // occur within WIDTH+nstall MUL cycles.
        while (placed < nstall) begin
            p = $urandom_range(0, WIDTH + nstall - 2);
            if (pat[p]) begin
                pat[p] = 1'b0;
                placed++;
            end
        end
        op_a = a; op_b = b; start = 1'b1;
        sb.push_back('{prod: {32'd0, a} * {32'd0, b}, lat: WIDTH + 1 + nstall});
        @(posedge clk); #1;
        start = 1'b0;
        k = 0;
        while (busy && k < 200) begin
            alu_gnt = (k < 42) ? pat[k] : 1'b1;
            if (poke && (k == 4 || k == WIDTH)) begin
                start = 1'b1; op_a = ~a; op_b = b + 32'd1;
            end else begin
                start = 1'b0;
            end
            @(posedge clk); #1;
            k++;
        end
        start = 1'b0;
        alu_gnt = 1'b1;
        if (k >= 200) check("busy_timeout", 64'(busy), 64'd0);
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b0; start = 1'b0; alu_gnt = 1'b1; op_a = '0; op_b = '0;
        #1 reset = 1'b1;
        #2;
        check("rst_hilo", {hi, lo}, 64'd0);
        check("rst_ctl", {61'd0, busy, done, alu_req}, 64'd0);
        @(posedge clk); @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;

        run_mul(32'd3, 32'd5, 0, 1'b0);
        run_mul(32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 1'b0);
        run_mul(32'h8000_0000, 32'd2, 0, 1'b0);
        run_mul(32'h1234_5678, 32'd0, 0, 1'b0);
        run_mul(32'd3, 32'd5, 10, 1'b0);
        run_mul(32'hCAFE_0123, 32'h0000_BEEF, 0, 1'b1);
        check("idle_after_poke", {62'd0, busy, done}, 64'd0);

        // Reset in the 12th MUL cycle: everything drops immediately.
        op_a = 32'h1111_2222; op_b = 32'h3333_4444; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (11) begin
            @(posedge clk); #1;
        end
        check("pre_reset_busy", 64'(busy), 64'd1);
        reset = 1'b1;
        #1;
        check("mid_rst_ctl", {61'd0, busy, done, alu_req}, 64'd0);
        check("mid_rst_hilo", {hi, lo}, 64'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
        end
        run_mul(32'd7, 32'd6, 0, 1'b0);
        check("lo_after_reset", 64'(lo), 64'd42);

        for (int i = 0; i < 3; i++) begin
            run_mul($urandom, $urandom, $urandom_range(0, 10), 1'b0);
        end

        check("sb_empty", 64'(sb.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/muldiv_seq.md
Name: muldiv_seq

Overview:
- Multi-cycle unsigned multiply sequencer (MULTU) for the MIPS core.
- Implements shift-add multiplication by borrowing the shared 32-bit ALU one iteration per granted cycle, using only the add operation (alucontrol 3'b010).
- Holds the 64-bit product in HI/LO registers read by mfhi/mflo.
- Sits beside the ALU; the ALU source mux and arbiter select this block's operands while alu_gnt is high.

Parameters:
WIDTH, 32, operand width; HI and LO are each WIDTH bits.
CNT_W, 6, iteration counter width; must satisfy 2**CNT_W > WIDTH.

Ports:
clk  input  1  system clock, rising edge.
reset  input  1  asynchronous, active-high reset.
start  input  1  one-cycle request to begin a MULTU; sampled only in IDLE.
op_a  input  WIDTH  multiplicand (rs), sampled with start.
op_b  input  WIDTH  multiplier (rt), sampled with start.
busy  output  1  high in MUL and DONE; the pipeline stalls mfhi/mflo/mult while high.
done  output  1  one-cycle pulse when HI/LO hold the final product.
hi  output  WIDTH  upper product word.
lo  output  WIDTH  lower product word.
alu_req  output  1  request for the shared ALU.
alu_gnt  input  1  grant from the arbiter; valid in the same cycle as alu_req.
alu_srca  output  WIDTH  ALU operand A.
alu_srcb  output  WIDTH  ALU operand B.
alu_control  output  3  ALU opcode.
alu_out  input  WIDTH  combinational ALU result for the current operands.

Behaviour:

Reset:
- Applies asynchronously.
- State=IDLE; hi, lo, multiplicand register and count = 0.
- busy=0, done=0, alu_req=0.

State machine:
- States are IDLE, MUL and DONE.
- IDLE -> MUL on start: mcand<=op_a, lo<=op_b, hi<=0, count<=0.
- MUL -> DONE when an iteration completes with count==WIDTH-1.
- DONE -> IDLE unconditionally after one cycle.

MUL outputs (combinational from state):
- alu_req=1.
- alu_srca=hi.
- alu_srcb = lo[0] ? mcand : 0.
- alu_control=3'b010.
- Outside MUL: alu_req=0, alu_srca=0, alu_srcb=0, alu_control=3'b000.

Iteration (in MUL, only on a cycle with alu_gnt=1):
- carry = (srca[31]&srcb[31]) | ((srca[31]|srcb[31]) & ~alu_out[31]). This is computed locally because the ALU has no carry out.
- hi <= {carry, alu_out[WIDTH-1:1]}.
- lo <= {alu_out[0], lo[WIDTH-1:1]}.
- count <= count+1.

Stall:
- In MUL with alu_gnt=0, all registers hold.
- alu_req stays high.

Latency:
- Exactly WIDTH granted MUL cycles, then DONE.
- Minimum is start to done = WIDTH+1 cycles.

Outputs by state:
- busy=1 in MUL and DONE.
- done=1 only in DONE.
- hi/lo are valid from the DONE cycle and hold until the next accepted start.

Boundary conditions:
- start in MUL or DONE: ignored; no restart and no queuing.
- start in the same cycle as DONE: ignored, because the state is not yet IDLE.
- alu_gnt while not in MUL: ignored.
- Reset mid-MUL: immediate return to IDLE; hi/lo cleared; alu_req drops asynchronously.
- Operand 0: still runs the full WIDTH iterations; no early exit.
- alu_out is trusted only in cycles with alu_req&alu_gnt.

Test Plan:
1. Reset, then start with op_a=3, op_b=5 and alu_gnt held high -> done pulses exactly 33 cycles after start; hi=0x00000000, lo=0x0000000F; busy is high for 33 cycles.
2. op_a=0xFFFFFFFF, op_b=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001. This checks the local carry logic on every iteration.
3. op_a=0x80000000, op_b=2 -> hi=0x00000001, lo=0x00000000. Separately, op_a=0x12345678, op_b=0 -> hi=lo=0 after 33 cycles.
4. 3*5 with alu_gnt deasserted on 10 random MUL cycles -> hi/lo/count frozen on those cycles; done arrives at 43 cycles; result 15. alu_req is high throughout MUL and alu_control=3'b010.
5. Pulse start again at cycles 5 and 33 of an active operation with different operands -> ignored; the result matches the first operands; the state returns to IDLE after DONE.
6. Assert reset at MUL cycle 12 -> immediate busy=0, alu_req=0, hi=lo=0, no done pulse. A start after reset release with op_a=7, op_b=6 yields lo=42.
